serialdiv: RTL and testbench
============================

# serialdiv

Iterative restoring divider: one quotient bit per clock, sized to sit beside the serial multiplier as the hi/lo datapath for div/divu instructions. Takes two operands and a start pulse. Produces quotient and remainder packed into one result word, with a valid flag, in the same hi/lo layout as the multiplier's product. Signed and unsigned division are both supported through a per-operation sign select.

## Interface
- WIDTH, 32, operand width; result is 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- dst  in  1  start pulse; operands sampled when accepted.
- dsgn  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with dst.
- a  in  WIDTH  dividend.
- b  in  WIDTH  divisor.
- res  out  2*WIDTH  {remainder, quotient}: remainder in bits [2W-1:W] (hi), quotient in bits [W-1:0] (lo).
- resv  out  1  result valid; high while res holds a completed result.

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE or DONE, dst=1:
  - latch |a|, |b|, dsgn, sign(a), sign(b), and b==0; abs is applied only when dsgn=1.
  - clear the partial remainder, count=0, go to RUN.
  - drop resv to 0; res holds its old value.
- RUN, each cycle:
  - shift {rem, dividend} left by 1.
  - trial = rem − |b| (W+1 bits).
  - if trial ≥ 0, rem = trial and quotient bit = 1; else the quotient bit is 0.
  - count++; after iteration WIDTH−1, go to FIX.
- FIX, sign correction when dsgn=1:
  - negate the quotient iff sign(a)≠sign(b).
  - negate the remainder iff sign(a)=1.
  - then write res, set resv=1, go to DONE.
- DONE: hold res and resv until the next accepted dst or reset.
- dst during RUN or FIX is ignored. No abort, no restart.
- Divide by zero (b==0, either mode): quotient = all ones, remainder = a unmodified. This overrides the sign fix.
- Signed overflow (a=0x80000000, b=0xFFFFFFFF): quotient 0x80000000, remainder 0. This falls out of the magnitude algorithm; no special case is needed.
- Remainder always takes the dividend's sign; quotient truncates toward zero.

## Timing
- Reset (rst=0 at an edge): state IDLE, res=0, resv=0, count=0. This applies in any state, including mid-RUN. The in-flight operation is discarded.
- dst accepted at edge k: resv=0 after edge k.
- RUN iterations occur on edges k+1 … k+WIDTH.
- FIX is evaluated on edge k+WIDTH+1.
- res valid and resv=1 after edge k+WIDTH+1: latency 33 cycles for WIDTH=32.
- Back-to-back: dst may be asserted in the first DONE cycle. It is accepted on that edge and resv falls after it.
- dst and rst low on the same edge: reset wins.
- Operands a, b need only be stable on the accepting edge.

## Structure
- Shared package:
  - WIDTH default.
  - State encoding: IDLE/RUN/FIX/DONE.
  - DIV0_QUOT constant (all ones).
  - hi/lo field index constants, shared with the multiplier.
- Sub-module: serialdiv_step, combinational.
  - Inputs: rem, next dividend bit, |b|.
  - Outputs: new rem, quotient bit.
  - Keeps the iteration cell separately testable.
- Sign absolute-value and negation logic lives in the top module.

## Test plan
- Unsigned 100/7 (dsgn=0) → res=64'h00000002_0000000E; resv rises exactly 33 cycles after dst edge.
- Signed −7/2 (a=0xFFFFFFF9, b=2) → quot 0xFFFFFFFD, rem 0xFFFFFFFF. Signed 7/−2 → quot 0xFFFFFFFD, rem 0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → quot 0x80000000, rem 0. Same operands unsigned → quot 0, rem 0x80000000.
- Divide by zero, a=0x12345678, b=0, both dsgn values → quot 0xFFFFFFFF, rem 0x12345678, normal latency.
- dst re-pulsed at cycle 5 of RUN with new operands → ignored; first result delivered unchanged. Unsigned 0xFFFFFFFF/0x80000000 → quot 1, rem 0x7FFFFFFF.
- rst=0 at cycle 10 of RUN → res=0, resv=0 next cycle. A new dst after reset completes normally with correct result.

Source files
------------

// File: rtl/serialdiv_pkg.sv
// Shared definitions for the serial divider (and the matching hi/lo layout of the serial multiplier).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serialdiv_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient reported for any divide by zero.
    localparam logic [DEF_WIDTH-1:0] DIV0_QUOT = '1;

    // Result word layout: {hi, lo} = {remainder, quotient} here, {high, low} product in the multiplier.
    localparam int LO_LSB = 0;
    localparam int LO_MSB = DEF_WIDTH - 1;
    localparam int HI_LSB = DEF_WIDTH;
    localparam int HI_MSB = 2 * DEF_WIDTH - 1;

endpackage

// File: rtl/serialdiv_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, consumed by the top only in RUN.
module serialdiv_step
    import serialdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             din,
    input  logic [WIDTH-1:0] absb,
    output logic [WIDTH-1:0] rem_nxt,
    output logic             qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    // Shifted remainder needs W+1 bits; the difference always fits in W bits when it is kept.
    always_comb begin
        shifted = {rem, din};
        diff    = shifted[WIDTH-1:0] - absb;
        qbit    = (shifted >= {1'b0, absb});
        rem_nxt = qbit ? diff : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/serialdiv.sv
// Iterative signed/unsigned divider, one quotient bit per clock, result {remainder, quotient}.
// Latency: WIDTH+1 cycles from the accepting dst edge to resv=1 (33 for WIDTH=32).
// Backpressure: dst is accepted only in IDLE/DONE; pulses during RUN/FIX are dropped.
module serialdiv
    import serialdiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               dst,
    input  logic               dsgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] res,
    output logic               resv
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] dvd;    // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] absb;
    logic [WIDTH-1:0] araw;   // unmodified dividend, reported as remainder on divide by zero
    logic             sa;     // dividend negative (signed mode only)
    logic             sb;     // divisor negative (signed mode only)
    logic             bz;

    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic [WIDTH-1:0] rem_nxt;
    logic             qbit;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // Magnitudes of the incoming operands; two's complement abs only in signed mode.
    always_comb begin
        a_abs = (dsgn && a[WIDTH-1]) ? -a : a;
        b_abs = (dsgn && b[WIDTH-1]) ? -b : b;
    end

    serialdiv_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .din     (dvd[WIDTH-1]),
        .absb    (absb),
        .rem_nxt (rem_nxt),
        .qbit    (qbit)
    );

    // Sign fix-up of the magnitude result; divide by zero overrides it.
    always_comb begin
        q_fix = (sa ^ sb) ? -dvd : dvd;
        r_fix = sa ? -rem : rem;
        if (bz) begin
            q_fix = WIDTH'(DIV0_QUOT);
            r_fix = araw;
        end
    end

    // Control FSM and datapath; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            res   <= '0;
            resv  <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (dst) begin
                        dvd   <= a_abs;
                        absb  <= b_abs;
                        araw  <= a;
                        sa    <= dsgn & a[WIDTH-1];
                        sb    <= dsgn & b[WIDTH-1];
                        bz    <= (b == '0);
                        rem   <= '0;
                        count <= '0;
                        resv  <= 1'b0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    rem   <= rem_nxt;
                    dvd   <= {dvd[WIDTH-2:0], qbit};
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    res   <= {r_fix, q_fix};
                    resv  <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serialdiv.sv
// Directed bench for serialdiv: vector table plus hand-written restart/reset sequences.
// Latency: checks resv rises exactly 33 edges after the accepting edge.
// Backpressure: checks dst is ignored while busy and accepted in the first DONE cycle.
module tb_serialdiv;
    import serialdiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        dst;
    logic        dsgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        resv;

    int checks;
    int errors;
    logic [63:0] prev_res;

    typedef struct {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vt[13];

    serialdiv #(.WIDTH(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .dst  (dst),
        .dsgn (dsgn),
        .a    (a),
        .b    (b),
        .res  (res),
        .resv (resv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic chk_res(input string nm, input logic [63:0] exp);
        logic [63:0] act;
        act = res;
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual rem=%h quot=%h required rem=%h quot=%h", nm,
                     act[HI_MSB:HI_LSB], act[LO_MSB:LO_LSB], exp[HI_MSB:HI_LSB], exp[LO_MSB:LO_LSB]);
        end
    endtask

    // Wait for resv after an accepting edge; returns number of edges taken (41 on timeout).
    task automatic wait_resv(output int n);
        n = 0;
        while (!resv && n <= 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_div(input string nm, input logic s, input logic [31:0] av,
                          input logic [31:0] bv, input logic [63:0] exp);
        int n;
        @(negedge clk);
        dst  = 1'b1;
        dsgn = s;
        a    = av;
        b    = bv;
        @(posedge clk);
        #1;
        dst = 1'b0;
        a   = 32'hDEADBEEF;
        b   = 32'h0BADF00D;
        chk({nm, "_accept_resv"}, {63'd0, resv}, 64'd0);
        chk_res({nm, "_hold_old_res"}, prev_res);
        wait_resv(n);
        chk({nm, "_latency"}, 64'(n), 64'd33);
        chk_res({nm, "_res"}, exp);
        prev_res = exp;
    endtask

    initial begin
        int n;
        checks   = 0;
        errors   = 0;
        prev_res = 64'd0;
        rst  = 1'b0;
        dst  = 1'b0;
        dsgn = 1'b0;
        a    = 32'd0;
        b    = 32'd0;

        vt[0]  = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E};
        vt[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD};
        vt[2]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD};
        vt[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000};
        vt[4]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   64'h80000000_00000000};
        vt[5]  = '{1'b0, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF};
        vt[6]  = '{1'b1, 32'h12345678,   32'd0,          64'h12345678_FFFFFFFF};
        vt[7]  = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   64'h7FFFFFFF_00000001};
        vt[8]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          64'hFFFFFFFE_FFFFFFF2};
        vt[9]  = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E};
        vt[10] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000};
        vt[11] = '{1'b1, 32'hFFFFFF00,   32'd0,          64'hFFFFFF00_FFFFFFFF};
        vt[12] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_resv", {63'd0, resv}, 64'd0);
        chk_res("reset_res", 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table: consecutive entries start in the first DONE cycle of the previous one
        for (int i = 0; i < 13; i++) begin
            do_div($sformatf("vec%0d", i), vt[i].s, vt[i].a, vt[i].b, vt[i].exp);
        end

        // dst re-pulsed during RUN must be ignored
        @(negedge clk);
        dst = 1'b1; dsgn = 1'b0; a = 32'hFFFFFFFF; b = 32'h80000000;
        @(posedge clk);
        #1;
        dst = 1'b0;
        n = 0;
        while (!resv && n <= 40) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 5) begin
                dst = 1'b1; dsgn = 1'b1; a = 32'd100; b = 32'd7;
            end else if (n == 6) begin
                dst = 1'b0;
            end
        end
        chk("repulse_latency", 64'(n), 64'd33);
        chk_res("repulse_res", 64'h7FFFFFFF_00000001);
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold_resv", {63'd0, resv}, 64'd1);
        chk_res("done_hold_res", 64'h7FFFFFFF_00000001);

        // Reset at cycle 10 of RUN
        @(negedge clk);
        dst = 1'b1; dsgn = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        dst = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrun_reset_resv", {63'd0, resv}, 64'd0);
        chk_res("midrun_reset_res", 64'd0);
        rst = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("midrun_reset_stays_idle", {63'd0, resv}, 64'd0);
        prev_res = 64'd0;
        do_div("after_reset", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD);

        // dst and reset on the same edge: reset wins, nothing starts
        @(negedge clk);
        rst = 1'b0; dst = 1'b1; dsgn = 1'b0; a = 32'd100; b = 32'd7;
        @(posedge clk);
        #1;
        rst = 1'b1; dst = 1'b0;
        chk("rst_dst_resv", {63'd0, resv}, 64'd0);
        chk_res("rst_dst_res", 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("rst_dst_no_start", {63'd0, resv}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
